// File: rtl/key_repeat_pkg.sv
// key_repeat_pkg
//   Shared definitions for the key auto-repeat block:
//   - kr_state_t : per-channel FSM state encoding (2-bit enum)
//   - default timing constants for a 50 MHz clock (0.5 s delay, 0.1 s rate)
//   - kr_is_held : helper mapping a state to the key_held level
package key_repeat_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,  // key seen high at reset; wait for a clean release
    IDLE     = 2'd1,  // released, waiting for a press
    DELAY    = 2'd2,  // held, counting the initial auto-repeat delay
    REPEAT   = 2'd3   // held, emitting pulses at the repeat rate
  } kr_state_t;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DEF_NUM_KEYS  = 5;
  localparam int DEF_DELAY_CYC = CLK_HZ / 2;   // 0.5 s
  localparam int DEF_RATE_CYC  = CLK_HZ / 10;  // 0.1 s
  localparam int DEF_CNT_W     = 25;           // 2^25 > 25_000_000

  // key_held is asserted in exactly the states where the key is armed
  function automatic logic kr_is_held(input kr_state_t st);
    return (st == DELAY) || (st == REPEAT);
  endfunction

endpackage

// File: rtl/key_repeat_chan.sv
// key_repeat_chan
//   One key channel: press/repeat/release FSM plus its delay/rate counter.
//   All outputs are registered.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   key_level      : debounced key level, 1 = pressed
//   repeat_en      : auto-repeat enable for this key
//   key_pulse      : one-cycle pulse on press and on every repeat
//   release_pulse  : one-cycle pulse when an armed (DELAY/REPEAT) key is released
//   key_held       : 1 while the channel is in DELAY or REPEAT
module key_repeat_chan
  import key_repeat_pkg::*;
#(
  parameter int DELAY_CYC = DEF_DELAY_CYC,  // >= 2
  parameter int RATE_CYC  = DEF_RATE_CYC,   // >= 2
  parameter int CNT_W     = DEF_CNT_W       // 2^CNT_W > max(DELAY_CYC, RATE_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_level,
  input  logic repeat_en,
  output logic key_pulse,
  output logic release_pulse,
  output logic key_held
);

  localparam logic [CNT_W-1:0] DELAY_TERM = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_TERM  = CNT_W'(RATE_CYC - 1);

  kr_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Release is tested before the terminal count in every armed state, so a
  // release landing on a terminal cycle yields release_pulse only. That also
  // guarantees key_pulse and release_pulse are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_REL;
      cnt           <= '0;
      key_pulse     <= 1'b0;
      release_pulse <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      key_pulse     <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        // A key held through reset must be released before it can press.
        WAIT_REL: begin
          if (!key_level) state <= IDLE;
        end

        IDLE: begin
          if (key_level) begin
            state     <= DELAY;
            cnt       <= '0;
            key_pulse <= 1'b1;
            key_held  <= kr_is_held(DELAY);
          end
        end

        DELAY: begin
          if (!key_level) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            key_held      <= kr_is_held(IDLE);
          end else if (cnt == DELAY_TERM) begin
            // With repeat disabled the counter parks at its terminal value,
            // so enabling repeat later fires on the very next edge.
            if (repeat_en) begin
              state     <= REPEAT;
              cnt       <= '0;
              key_pulse <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        REPEAT: begin
          if (!key_level) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            key_held      <= kr_is_held(IDLE);
          end else if (!repeat_en) begin
            // Drop back to a saturated DELAY; re-enabling resumes at once.
            state <= DELAY;
            cnt   <= DELAY_TERM;
          end else if (cnt == RATE_TERM) begin
            cnt       <= '0;
            key_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= WAIT_REL;
          cnt      <= '0;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_repeat.sv
// key_repeat
//   Turns debounced push-button levels into single-cycle action pulses for
//   the game controller: one pulse on press, auto-repeat pulses while held
//   (per-key enable), a release pulse and a held level. Channels are fully
//   independent; no arbitration between keys is done here.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   key_level      : [NUM_KEYS] debounced levels, 1 = pressed
//   repeat_en      : [NUM_KEYS] per-key auto-repeat enable
//   key_pulse      : [NUM_KEYS] press / repeat pulse
//   release_pulse  : [NUM_KEYS] release pulse for armed keys
//   key_held       : [NUM_KEYS] 1 while the key is in DELAY or REPEAT
module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int NUM_KEYS  = DEF_NUM_KEYS,
  parameter int DELAY_CYC = DEF_DELAY_CYC,
  parameter int RATE_CYC  = DEF_RATE_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_level,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] key_held
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_repeat_chan #(
      .DELAY_CYC (DELAY_CYC),
      .RATE_CYC  (RATE_CYC),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .key_level     (key_level[i]),
      .repeat_en     (repeat_en[i]),
      .key_pulse     (key_pulse[i]),
      .release_pulse (release_pulse[i]),
      .key_held      (key_held[i])
    );
  end

endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat
//   Directed bench for key_repeat with DELAY_CYC=8, RATE_CYC=4, NUM_KEYS=2.
//   Cycle c is the interval after the c-th clock edge following reset
//   deassertion; inputs changed in cycle c are sampled at edge c+1.
module tb_key_repeat;

  localparam int NK = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_level = '0;
  logic [NK-1:0] repeat_en = '0;
  logic [NK-1:0] key_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] key_held;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  key_repeat #(
    .NUM_KEYS  (NK),
    .DELAY_CYC (8),
    .RATE_CYC  (4),
    .CNT_W     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_level     (key_level),
    .repeat_en     (repeat_en),
    .key_pulse     (key_pulse),
    .release_pulse (release_pulse),
    .key_held      (key_held)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string sc, input int c,
                         input logic [1:0] kp, input logic [1:0] rp, input logic [1:0] hd);
    chk($sformatf("%s key_pulse c%0d", sc, c), 32'(key_pulse), 32'(kp));
    chk($sformatf("%s release_pulse c%0d", sc, c), 32'(release_pulse), 32'(rp));
    chk($sformatf("%s key_held c%0d", sc, c), 32'(key_held), 32'(hd));
  endtask

  // Leaves the bench in cycle 0 with rst just deasserted.
  task automatic do_reset(input string sc, input logic [1:0] kl, input logic [1:0] re);
    rst = 1'b1;
    key_level = kl;
    repeat_en = re;
    tick;
    tick;
    chk_cyc({sc, " reset"}, 0, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
  endtask

  initial begin
    // 1: key held through reset gives nothing until released and re-pressed
    do_reset("s1", 2'b01, 2'b01);
    for (int c = 1; c <= 30; c++) begin
      tick;
      chk_cyc("s1", c, {1'b0, c == 26}, 2'b00, {1'b0, c >= 26});
      if (c == 20) key_level[0] = 1'b0;
      if (c == 25) key_level[0] = 1'b1;
    end

    // 2: press, delay, repeat, release
    do_reset("s2", 2'b00, 2'b01);
    for (int c = 1; c <= 40; c++) begin
      tick;
      chk_cyc("s2", c,
              {1'b0, c == 11 || c == 19 || c == 23 || c == 27 || c == 31},
              {1'b0, c == 34},
              {1'b0, c >= 11 && c <= 33});
      if (c == 10) key_level[0] = 1'b1;
      if (c == 33) key_level[0] = 1'b0;
    end

    // 3: repeat disabled saturates; enabling fires on the next edge
    do_reset("s3", 2'b00, 2'b00);
    for (int c = 1; c <= 40; c++) begin
      tick;
      chk_cyc("s3", c,
              {1'b0, c == 11 || c == 31 || c == 35 || c == 39},
              2'b00,
              {1'b0, c >= 11});
      if (c == 10) key_level[0] = 1'b1;
      if (c == 30) repeat_en[0] = 1'b1;
    end

    // 4: release sampled on the terminal-count edge wins over the repeat
    do_reset("s4", 2'b00, 2'b01);
    for (int c = 1; c <= 32; c++) begin
      tick;
      chk_cyc("s4", c,
              {1'b0, c == 11 || c == 19 || c == 23},
              {1'b0, c == 27},
              {1'b0, c >= 11 && c <= 26});
      if (c == 10) key_level[0] = 1'b1;
      if (c == 26) key_level[0] = 1'b0;
    end

    // 5: reset mid-REPEAT with key still held
    do_reset("s5", 2'b00, 2'b01);
    for (int c = 1; c <= 36; c++) begin
      tick;
      chk_cyc("s5", c,
              {1'b0, c == 11 || c == 19 || c == 34},
              2'b00,
              {1'b0, (c >= 11 && c <= 21) || c >= 34});
      if (c == 10) key_level[0] = 1'b1;
      if (c == 21) rst = 1'b1;
      if (c == 22) rst = 1'b0;
      if (c == 30) key_level[0] = 1'b0;
      if (c == 33) key_level[0] = 1'b1;
    end

    // 6: two keys pressed together, released independently
    do_reset("s6", 2'b00, 2'b11);
    for (int c = 1; c <= 32; c++) begin
      tick;
      chk_cyc("s6", c,
              {c == 11 || c == 19 || c == 23 || c == 27, c == 11 || c == 19},
              {c == 29, c == 21},
              {c >= 11 && c <= 28, c >= 11 && c <= 20});
      if (c == 10) key_level = 2'b11;
      if (c == 20) key_level[0] = 1'b0;
      if (c == 28) key_level[1] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
